// File: rtl/bullet_engine.sv
// Bullet engine for one tank: launches a shot on a fire rising edge, steps it
// one pixel every MOVE_TIME+1 cycles, detects hits on the opposing tank and
// collisions with the fixed 16x16 tile map, then holds an explosion.
module bullet_engine #(
  parameter int MOVE_TIME    = 200000,
  parameter int EXPLODE_TIME = 4000000,
  parameter int OWNER        = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_over,
  input  logic        fire,
  input  logic [1:0]  fire_dir,
  input  logic [9:0]  tank_x,
  input  logic [9:0]  tank_y,
  input  logic [9:0]  target_x,
  input  logic [9:0]  target_y,
  input  logic        target_active,
  output logic        hit,
  output logic [9:0]  bullet_x,
  output logic [9:0]  bullet_y,
  output logic        busy,
  output logic [31:0] bullet_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FLYING  = 2'd1;
  localparam logic [1:0] S_EXPLODE = 2'd2;

  localparam logic [31:0] MOVE_LOAD    = 32'(MOVE_TIME);
  // The explode counter runs down to zero inclusive, so load one less.
  localparam logic [31:0] EXPLODE_LOAD = (EXPLODE_TIME > 0) ? 32'(EXPLODE_TIME - 1) : 32'd0;

  // OWNER names one of four players; anything else is a build error.
  generate
    if (OWNER < 0 || OWNER > 3) begin : g_owner_check
      $error("bullet_engine: OWNER must be in 0..3");
    end
  endgenerate

  logic [1:0]  state;
  logic [1:0]  dir;
  logic [31:0] move_cnt;
  logic [31:0] explode_cnt;
  logic        fire_q;
  logic        fire_hold;
  logic        fire_rise;

  logic [9:0]  cand_x;
  logic [9:0]  cand_y;
  logic [9:0]  cand_x_hi;
  logic [9:0]  cand_y_hi;
  logic        off_field;
  logic        wall_test;
  logic        hit_test;

  // Tile map lookup: row = x/32, column = y/32; anything outside the 16x16
  // map counts as wall.
  function automatic logic map_wall(input logic [4:0] row, input logic [4:0] col);
    logic [15:0] word;
    case (row)
      5'd0:    word = 16'hFFFF;
      5'd1:    word = 16'h8001;
      5'd2:    word = 16'hB555;
      5'd3:    word = 16'hA015;
      5'd4:    word = 16'hAEE5;
      5'd5:    word = 16'hA005;
      5'd6:    word = 16'hAE75;
      5'd7:    word = 16'hA005;
      5'd8:    word = 16'hAEE5;
      5'd9:    word = 16'hA005;
      5'd10:   word = 16'hB555;
      5'd11:   word = 16'h8001;
      5'd12:   word = 16'hD557;
      5'd13:   word = 16'h8001;
      5'd14:   word = 16'hFFFF;
      5'd15:   word = 16'hFFFF;
      default: word = 16'hFFFF;
    endcase
    if (col[4]) return 1'b1;
    return word[4'd15 - col[3:0]];
  endfunction

  // Fire is a level; a shot is only taken on a fresh rise that was not
  // already held through reset.
  assign fire_rise = fire && !fire_q && !fire_hold;

  // Candidate position one pixel along the current direction.
  always_comb begin
    cand_x = bullet_x;
    cand_y = bullet_y;
    case (dir)
      2'b00:   cand_y = bullet_y - 10'd1;
      2'b01:   cand_y = bullet_y + 10'd1;
      2'b10:   cand_x = bullet_x - 10'd1;
      default: cand_x = bullet_x + 10'd1;
    endcase
  end

  assign cand_x_hi = cand_x + 10'd7;
  assign cand_y_hi = cand_y + 10'd7;

  // Stepping below 0 wraps to a large value, so one upper bound covers both edges.
  assign off_field = (cand_x > 10'd504) || (cand_y > 10'd504);

  assign wall_test = off_field
                   || map_wall(cand_x[9:5],    cand_y[9:5])
                   || map_wall(cand_x_hi[9:5], cand_y[9:5])
                   || map_wall(cand_x[9:5],    cand_y_hi[9:5])
                   || map_wall(cand_x_hi[9:5], cand_y_hi[9:5]);

  // 8x8 bullet box against 32x32 target box, inclusive on both ends.
  assign hit_test = target_active
                 && ({1'b0, cand_x} <= ({1'b0, target_x} + 11'd31))
                 && (({1'b0, cand_x} + 11'd7) >= {1'b0, target_x})
                 && ({1'b0, cand_y} <= ({1'b0, target_y} + 11'd31))
                 && (({1'b0, cand_y} + 11'd7) >= {1'b0, target_y});

  // Main FSM: launch, timed flight steps with hit/wall resolution, explosion hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      hit         <= 1'b0;
      bullet_x    <= 10'd0;
      bullet_y    <= 10'd0;
      dir         <= 2'b00;
      move_cnt    <= 32'd0;
      explode_cnt <= 32'd0;
      fire_q      <= 1'b0;
      fire_hold   <= fire;
    end else begin
      fire_q <= fire;
      if (!fire) fire_hold <= 1'b0;
      hit <= 1'b0;
      if (game_over) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (fire_rise) begin
              dir      <= fire_dir;
              bullet_x <= tank_x + 10'd12;
              bullet_y <= tank_y + 10'd12;
              move_cnt <= MOVE_LOAD;
              state    <= S_FLYING;
            end
          end
          S_FLYING: begin
            if (move_cnt != 32'd0) begin
              move_cnt <= move_cnt - 32'd1;
            end else begin
              move_cnt <= MOVE_LOAD;
              if (hit_test) begin
                bullet_x    <= cand_x;
                bullet_y    <= cand_y;
                hit         <= 1'b1;
                explode_cnt <= EXPLODE_LOAD;
                state       <= S_EXPLODE;
              end else if (wall_test) begin
                explode_cnt <= EXPLODE_LOAD;
                state       <= S_EXPLODE;
              end else begin
                bullet_x <= cand_x;
                bullet_y <= cand_y;
              end
            end
          end
          S_EXPLODE: begin
            if (explode_cnt == 32'd0) state <= S_IDLE;
            else explode_cnt <= explode_cnt - 32'd1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy = (state == S_FLYING) || (state == S_EXPLODE);

  assign bullet_state = {1'b0, 2'b11, busy, bullet_x, bullet_y, dir, 3'b100,
                         (state == S_EXPLODE) ? 3'd1 : 3'd0};

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine with MOVE_TIME=2, EXPLODE_TIME=5.
module tb_bullet_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        game_over = 1'b0;
  logic        fire = 1'b0;
  logic [1:0]  fire_dir = 2'b00;
  logic [9:0]  tank_x = 10'd0;
  logic [9:0]  tank_y = 10'd0;
  logic [9:0]  target_x = 10'd400;
  logic [9:0]  target_y = 10'd400;
  logic        target_active = 1'b0;
  logic        hit;
  logic [9:0]  bullet_x;
  logic [9:0]  bullet_y;
  logic        busy;
  logic [31:0] bullet_state;

  int checks = 0;
  int failures = 0;
  int hit_cnt = 0;

  bullet_engine #(.MOVE_TIME(2), .EXPLODE_TIME(5), .OWNER(1)) dut (
    .clk(clk), .reset(reset), .game_over(game_over), .fire(fire),
    .fire_dir(fire_dir), .tank_x(tank_x), .tank_y(tank_y),
    .target_x(target_x), .target_y(target_y), .target_active(target_active),
    .hit(hit), .bullet_x(bullet_x), .bullet_y(bullet_y), .busy(busy),
    .bullet_state(bullet_state)
  );

  always #5 clk = ~clk;

  // One clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (hit === 1'b1) hit_cnt++;
  endtask

  // Idle-state launch: drop fire, set up tank/dir, then raise fire.
  task automatic launch(input logic [9:0] tx, input logic [9:0] ty, input logic [1:0] d);
    fire = 1'b0;
    tank_x = tx;
    tank_y = ty;
    fire_dir = d;
    step();
    fire = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] exp_state;
    reset = 1'b1;
    repeat (3) step();
    exp_state = {1'b0, 2'b11, 1'b0, 10'd0, 10'd0, 2'b00, 3'b100, 3'b000};
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hit); end
    checks++; if (bullet_x !== 10'd0 || bullet_y !== 10'd0) begin failures++; $display("FAIL reset_pos got=(%0d,%0d) exp=(0,0)", bullet_x, bullet_y); end
    checks++; if (bullet_state !== exp_state) begin failures++; $display("FAIL reset_state got=%h exp=%h", bullet_state, exp_state); end
    reset = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_wall_y();
    logic [31:0] exp_state;
    int bad;
    int got;
    hit_cnt = 0;
    target_active = 1'b0;
    launch(10'd32, 10'd32, 2'b01);
    fire = 1'b0;
    exp_state = {1'b0, 2'b11, 1'b1, 10'd44, 10'd44, 2'b01, 3'b100, 3'b000};
    checks++; if (busy !== 1'b1 || bullet_x !== 10'd44 || bullet_y !== 10'd44) begin failures++; $display("FAIL wy_launch got busy=%b (%0d,%0d) exp busy=1 (44,44)", busy, bullet_x, bullet_y); end
    checks++; if (bullet_state !== exp_state) begin failures++; $display("FAIL wy_launch_state got=%h exp=%h", bullet_state, exp_state); end
    bad = -1; got = 0;
    for (int s = 1; s <= 428; s++) begin
      repeat (3) step();
      if (busy !== 1'b1 || bullet_x !== 10'd44 || bullet_y !== 10'(44 + s)) begin
        bad = s; got = int'(bullet_y); break;
      end
    end
    checks++; if (bad != -1) begin failures++; $display("FAIL wy_flight at step %0d got y=%0d exp y=%0d", bad, got, 44 + bad); end
    repeat (3) step();
    checks++; if (busy !== 1'b1 || bullet_y !== 10'd472 || bullet_state[2:0] !== 3'd1) begin failures++; $display("FAIL wy_wall got busy=%b y=%0d col=%0d exp busy=1 y=472 col=1", busy, bullet_y, bullet_state[2:0]); end
    repeat (4) step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wy_explode_hold got busy=%b exp=1", busy); end
    step();
    checks++; if (busy !== 1'b0 || bullet_y !== 10'd472 || bullet_state[2:0] !== 3'd0) begin failures++; $display("FAIL wy_idle got busy=%b y=%0d col=%0d exp busy=0 y=472 col=0", busy, bullet_y, bullet_state[2:0]); end
    checks++; if (hit_cnt !== 0) begin failures++; $display("FAIL wy_no_hit got=%0d exp=0", hit_cnt); end
  endtask

  task automatic test_wall_x();
    int bad;
    int got;
    hit_cnt = 0;
    launch(10'd32, 10'd32, 2'b11);
    fire = 1'b0;
    checks++; if (busy !== 1'b1 || bullet_x !== 10'd44 || bullet_y !== 10'd44) begin failures++; $display("FAIL wx_launch got busy=%b (%0d,%0d) exp busy=1 (44,44)", busy, bullet_x, bullet_y); end
    bad = -1; got = 0;
    for (int s = 1; s <= 332; s++) begin
      repeat (3) step();
      if (busy !== 1'b1 || bullet_y !== 10'd44 || bullet_x !== 10'(44 + s)) begin
        bad = s; got = int'(bullet_x); break;
      end
    end
    checks++; if (bad != -1) begin failures++; $display("FAIL wx_flight at step %0d got x=%0d exp x=%0d", bad, got, 44 + bad); end
    repeat (3) step();
    checks++; if (busy !== 1'b1 || bullet_x !== 10'd376 || bullet_state[2:0] !== 3'd1 || bullet_state[7:6] !== 2'b11) begin failures++; $display("FAIL wx_wall got busy=%b x=%0d state=%h exp busy=1 x=376 explode dir=11", busy, bullet_x, bullet_state); end
    repeat (5) step();
    checks++; if (busy !== 1'b0 || bullet_x !== 10'd376) begin failures++; $display("FAIL wx_idle got busy=%b x=%0d exp busy=0 x=376", busy, bullet_x); end
    checks++; if (hit_cnt !== 0) begin failures++; $display("FAIL wx_no_hit got=%0d exp=0", hit_cnt); end
  endtask

  task automatic test_hit();
    int bad;
    hit_cnt = 0;
    target_x = 10'd32; target_y = 10'd96; target_active = 1'b1;
    launch(10'd32, 10'd32, 2'b01);
    fire = 1'b0;
    bad = -1;
    for (int s = 1; s <= 44; s++) begin
      repeat (3) step();
      if (bullet_y !== 10'(44 + s) || hit !== 1'b0) begin bad = s; break; end
    end
    checks++; if (bad != -1) begin failures++; $display("FAIL hit_approach at step %0d got y=%0d hit=%b exp y=%0d hit=0", bad, bullet_y, hit, 44 + bad); end
    repeat (3) step();
    checks++; if (hit !== 1'b1 || bullet_y !== 10'd89 || busy !== 1'b1 || bullet_state[2:0] !== 3'd1) begin failures++; $display("FAIL hit_strike got hit=%b y=%0d busy=%b col=%0d exp hit=1 y=89 busy=1 col=1", hit, bullet_y, busy, bullet_state[2:0]); end
    step();
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL hit_one_cycle got=%b exp=0", hit); end
    repeat (3) step();
    checks++; if (busy !== 1'b1 || bullet_y !== 10'd89) begin failures++; $display("FAIL hit_explode got busy=%b y=%0d exp busy=1 y=89", busy, bullet_y); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hit_idle got busy=%b exp=0", busy); end
    checks++; if (hit_cnt !== 1) begin failures++; $display("FAIL hit_count got=%0d exp=1", hit_cnt); end
  endtask

  task automatic test_no_hit();
    int bad;
    hit_cnt = 0;
    target_x = 10'd32; target_y = 10'd96; target_active = 1'b0;
    launch(10'd32, 10'd32, 2'b01);
    fire = 1'b0;
    bad = -1;
    for (int s = 1; s <= 60; s++) begin
      repeat (3) step();
      if (bullet_y !== 10'(44 + s)) begin bad = s; break; end
    end
    checks++; if (bad != -1) begin failures++; $display("FAIL nohit_pass at step %0d got y=%0d exp y=%0d", bad, bullet_y, 44 + bad); end
    repeat (368 * 3) step();
    checks++; if (busy !== 1'b1 || bullet_y !== 10'd472 || bullet_state[2:0] !== 3'd0) begin failures++; $display("FAIL nohit_reach got busy=%b y=%0d col=%0d exp busy=1 y=472 col=0", busy, bullet_y, bullet_state[2:0]); end
    repeat (3) step();
    repeat (5) step();
    checks++; if (busy !== 1'b0 || bullet_y !== 10'd472) begin failures++; $display("FAIL nohit_idle got busy=%b y=%0d exp busy=0 y=472", busy, bullet_y); end
    checks++; if (hit_cnt !== 0) begin failures++; $display("FAIL nohit_count got=%0d exp=0", hit_cnt); end
  endtask

  task automatic test_back_to_back();
    target_active = 1'b0;
    launch(10'd32, 10'd32, 2'b01);
    repeat (3) step();
    checks++; if (bullet_y !== 10'd45) begin failures++; $display("FAIL b2b_first_step got y=%0d exp=45", bullet_y); end
    fire = 1'b0;
    step();
    fire = 1'b1;
    step();
    step();
    checks++; if (busy !== 1'b1 || bullet_x !== 10'd44 || bullet_y !== 10'd46) begin failures++; $display("FAIL b2b_ignored got busy=%b (%0d,%0d) exp busy=1 (44,46)", busy, bullet_x, bullet_y); end
    repeat (426 * 3) step();
    checks++; if (bullet_y !== 10'd472) begin failures++; $display("FAIL b2b_reach got y=%0d exp=472", bullet_y); end
    repeat (3) step();
    repeat (5) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got busy=%b exp=0", busy); end
    repeat (4) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_not_queued got busy=%b exp=0", busy); end
    launch(10'd64, 10'd32, 2'b01);
    checks++; if (busy !== 1'b1 || bullet_x !== 10'd76 || bullet_y !== 10'd44) begin failures++; $display("FAIL b2b_new_shot got busy=%b (%0d,%0d) exp busy=1 (76,44)", busy, bullet_x, bullet_y); end
    fire = 1'b0;
  endtask

  task automatic test_abort();
    logic [31:0] exp_state;
    // game_over during an ordinary flight
    repeat (6) step();
    checks++; if (busy !== 1'b1 || bullet_y !== 10'd46) begin failures++; $display("FAIL abort_pre got busy=%b y=%0d exp busy=1 y=46", busy, bullet_y); end
    game_over = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || hit !== 1'b0) begin failures++; $display("FAIL abort_go got busy=%b hit=%b exp busy=0 hit=0", busy, hit); end
    fire = 1'b0;
    step();
    fire = 1'b1;
    step();
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_go_block_fire got busy=%b exp=0", busy); end
    game_over = 1'b0;
    fire = 1'b0;
    step();
    // game_over on the very edge that would have struck the target
    hit_cnt = 0;
    target_x = 10'd32; target_y = 10'd96; target_active = 1'b1;
    launch(10'd32, 10'd32, 2'b01);
    repeat (44 * 3) step();
    repeat (2) step();
    game_over = 1'b1;
    step();
    checks++; if (hit !== 1'b0 || busy !== 1'b0 || bullet_y !== 10'd88) begin failures++; $display("FAIL abort_hit_suppress got hit=%b busy=%b y=%0d exp hit=0 busy=0 y=88", hit, busy, bullet_y); end
    game_over = 1'b0;
    step();
    checks++; if (hit_cnt !== 0) begin failures++; $display("FAIL abort_hit_count got=%0d exp=0", hit_cnt); end
    // reset mid-flight with fire held high through it
    target_active = 1'b0;
    launch(10'd32, 10'd32, 2'b01);
    repeat (9) step();
    reset = 1'b1;
    step();
    exp_state = {1'b0, 2'b11, 1'b0, 10'd0, 10'd0, 2'b00, 3'b100, 3'b000};
    checks++; if (busy !== 1'b0 || hit !== 1'b0 || bullet_x !== 10'd0 || bullet_y !== 10'd0) begin failures++; $display("FAIL abort_reset got busy=%b hit=%b (%0d,%0d) exp 0 0 (0,0)", busy, hit, bullet_x, bullet_y); end
    checks++; if (bullet_state !== exp_state) begin failures++; $display("FAIL abort_reset_state got=%h exp=%h", bullet_state, exp_state); end
    reset = 1'b0;
    repeat (5) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_fire_held got busy=%b exp=0", busy); end
    launch(10'd32, 10'd32, 2'b01);
    checks++; if (busy !== 1'b1 || bullet_x !== 10'd44 || bullet_y !== 10'd44) begin failures++; $display("FAIL reset_refire got busy=%b (%0d,%0d) exp busy=1 (44,44)", busy, bullet_x, bullet_y); end
    fire = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wall_y();
    test_wall_x();
    test_hit();
    test_no_hit();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
